// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, word type and line geometry helpers for the line controller
package cache_pkg;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WB_ISSUE = 3'd1;
  localparam logic [2:0] WB_WAIT  = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam int WORD_BYTES = 4;
  typedef logic [31:0] word_t;
  function automatic int line_off_bits(input int words);
    return $clog2(words) + $clog2(WORD_BYTES);
  endfunction
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts wait cycles for one memory word and flags when the budget is used up
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = enable && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // restart on every issue, advance only while waiting
  always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cache_line_mem_controller.sv
// cache_line_mem_controller: serialises line writeback/refill requests into single-word memory transactions
module cache_line_mem_controller import cache_pkg::*; #(
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wb,
  input  logic                         req_fill,
  input  logic [31:0]                  wb_addr,
  input  logic [31:0]                  fill_addr,
  input  logic [32*WORDS_PER_LINE-1:0] wb_line,
  output logic [32*WORDS_PER_LINE-1:0] fill_line,
  output logic                         done,
  output logic                         err,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_write_data,
  output logic                         mem_read,
  output logic                         mem_write,
  input  logic [31:0]                  mem_read_data,
  input  logic                         mem_ready
);
  localparam int OFF = line_off_bits(WORDS_PER_LINE);
  localparam int IW = $clog2(WORDS_PER_LINE);
  logic [2:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic wb_q, wb_d, fill_q, fill_d, err_q, err_d;
  logic [31:0] wb_base_q, wb_base_d, fill_base_q, fill_base_d;
  word_t [WORDS_PER_LINE-1:0] wb_line_q, wb_line_d, fill_line_q, fill_line_d;
  logic last, expired, rd_phase, unused_ok;
  assign unused_ok = ^{wb_addr[OFF-1:0], fill_addr[OFF-1:0]};
  assign last = idx_q == IW'(WORDS_PER_LINE - 1);
  assign rd_phase = state_q == RD_ISSUE || state_q == RD_WAIT;
  assign req_ready = state_q == IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign mem_write = state_q == WB_ISSUE;
  assign mem_read = state_q == RD_ISSUE;
  assign mem_addr = (rd_phase ? fill_base_q : wb_base_q) + 32'({idx_q, 2'b00});
  assign mem_write_data = wb_line_q[idx_q];
  assign fill_line = fill_line_q;
  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(mem_write || mem_read),
    .enable(state_q == WB_WAIT || state_q == RD_WAIT),
    .expired(expired)
  );
  // request capture and word sequencing; idx wraps to 0 naturally after the last word
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wb_d = wb_q;
    fill_d = fill_q;
    wb_base_d = wb_base_q;
    fill_base_d = fill_base_q;
    wb_line_d = wb_line_q;
    fill_line_d = fill_line_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        wb_d = req_wb;
        fill_d = req_fill;
        wb_base_d = {wb_addr[31:OFF], {OFF{1'b0}}};
        fill_base_d = {fill_addr[31:OFF], {OFF{1'b0}}};
        wb_line_d = wb_line;
        state_d = req_wb ? WB_ISSUE : req_fill ? RD_ISSUE : DONE;
      end
      WB_ISSUE: state_d = WB_WAIT;
      RD_ISSUE: state_d = RD_WAIT;
      WB_WAIT, RD_WAIT: if (mem_ready) begin
        if (state_q == RD_WAIT) fill_line_d[idx_q] = mem_read_data;
        idx_d = idx_q + 1'b1;
        state_d = !last ? state_q - 3'd1 : (state_q == WB_WAIT && fill_q) ? RD_ISSUE : DONE;
      end else if (expired) begin
        idx_d = '0;
        err_d = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      wb_q <= 1'b0;
      fill_q <= 1'b0;
      err_q <= 1'b0;
      wb_base_q <= '0;
      fill_base_q <= '0;
      wb_line_q <= '0;
      fill_line_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wb_q <= wb_d;
      fill_q <= fill_d;
      err_q <= err_d;
      wb_base_q <= wb_base_d;
      fill_base_q <= fill_base_d;
      wb_line_q <= wb_line_d;
      fill_line_q <= fill_line_d;
    end
endmodule
